// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered memory port between the fetch and load/store
// requesters, with a bounded wait that aborts a transaction the memory never acknowledges.
module mem_port_arbiter #(
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                f_clk,
    input  logic                f_rst,

    input  logic                a_i_syn,
    input  logic [AWIDTH-1:0]   a_i_addr,
    output logic                a_o_ack,
    output logic [DWIDTH-1:0]   a_o_rdata,
    output logic                a_o_err,

    input  logic                d_i_syn,
    input  logic                d_i_we,
    input  logic [AWIDTH-1:0]   d_i_addr,
    input  logic [DWIDTH-1:0]   d_i_wdata,
    input  logic [DWIDTH/8-1:0] d_i_sel,
    output logic                d_o_ack,
    output logic [DWIDTH-1:0]   d_o_rdata,
    output logic                d_o_err,

    output logic                m_o_stb,
    output logic                m_o_we,
    output logic [AWIDTH-1:0]   m_o_addr,
    output logic [DWIDTH-1:0]   m_o_wdata,
    output logic [DWIDTH/8-1:0] m_o_sel,
    input  logic                m_i_ack,
    input  logic [DWIDTH-1:0]   m_i_rdata,

    output logic [1:0]          o_grant
);

    localparam int unsigned SWIDTH = DWIDTH / 8;
    localparam int unsigned CWIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(TIMEOUT - 1);
    localparam logic [CWIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e              r_state, w_state_nxt;
    logic                r_last_d, w_last_d_nxt;
    logic [CWIDTH-1:0]   r_cnt, w_cnt_nxt;

    logic                r_stb, w_stb_nxt;
    logic                r_we, w_we_nxt;
    logic [AWIDTH-1:0]   r_addr, w_addr_nxt;
    logic [DWIDTH-1:0]   r_wdata, w_wdata_nxt;
    logic [SWIDTH-1:0]   r_sel, w_sel_nxt;
    logic [1:0]          r_grant, w_grant_nxt;

    logic                r_a_ack, w_a_ack_nxt;
    logic [DWIDTH-1:0]   r_a_rdata, w_a_rdata_nxt;
    logic                r_a_err, w_a_err_nxt;
    logic                r_d_ack, w_d_ack_nxt;
    logic [DWIDTH-1:0]   r_d_rdata, w_d_rdata_nxt;
    logic                r_d_err, w_d_err_nxt;

    logic                w_a_elig, w_d_elig, w_pick_d, w_busy, w_timeout, w_done;
    logic [DWIDTH-1:0]   w_resp_data;

    // A requester whose ack is on the bus this cycle is still holding syn; mask it out.
    assign w_a_elig    = a_i_syn && !r_a_ack;
    assign w_d_elig    = d_i_syn && !r_d_ack;
    assign w_pick_d    = w_d_elig && (!w_a_elig || !r_last_d);
    assign w_busy      = (r_state != StIdle);
    assign w_timeout   = w_busy && !m_i_ack && (r_cnt == CNT_LAST);
    assign w_done      = w_busy && (m_i_ack || w_timeout);
    assign w_resp_data = m_i_ack ? m_i_rdata : '0;

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_a_elig || w_d_elig) begin
                    w_state_nxt = w_pick_d ? StBusyD : StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                if (w_done) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_last_d_nxt  = r_last_d;
        w_cnt_nxt     = r_cnt;
        w_stb_nxt     = r_stb;
        w_we_nxt      = r_we;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_sel_nxt     = r_sel;
        w_grant_nxt   = r_grant;
        w_a_ack_nxt   = 1'b0;
        w_a_rdata_nxt = r_a_rdata;
        w_a_err_nxt   = 1'b0;
        w_d_ack_nxt   = 1'b0;
        w_d_rdata_nxt = r_d_rdata;
        w_d_err_nxt   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_a_elig || w_d_elig) begin
                    w_stb_nxt    = 1'b1;
                    w_cnt_nxt    = '0;
                    w_last_d_nxt = w_pick_d;
                    if (w_pick_d) begin
                        w_we_nxt    = d_i_we;
                        w_addr_nxt  = d_i_addr;
                        w_wdata_nxt = d_i_wdata;
                        w_sel_nxt   = d_i_sel;
                        w_grant_nxt = 2'b10;
                    end else begin
                        w_we_nxt    = 1'b0;
                        w_addr_nxt  = a_i_addr;
                        w_wdata_nxt = '0;
                        w_sel_nxt   = '1;
                        w_grant_nxt = 2'b01;
                    end
                end
            end
            StBusyI, StBusyD: begin
                if (w_done) begin
                    w_stb_nxt   = 1'b0;
                    w_grant_nxt = 2'b00;
                    if (r_state == StBusyD) begin
                        w_d_ack_nxt   = 1'b1;
                        w_d_rdata_nxt = w_resp_data;
                        w_d_err_nxt   = !m_i_ack;
                    end else begin
                        w_a_ack_nxt   = 1'b1;
                        w_a_rdata_nxt = w_resp_data;
                        w_a_err_nxt   = !m_i_ack;
                    end
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            r_last_d  <= 1'b0;
            r_cnt     <= '0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_grant   <= 2'b00;
            r_a_ack   <= 1'b0;
            r_a_rdata <= '0;
            r_a_err   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_rdata <= '0;
            r_d_err   <= 1'b0;
        end else begin
            r_last_d  <= w_last_d_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stb     <= w_stb_nxt;
            r_we      <= w_we_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_sel     <= w_sel_nxt;
            r_grant   <= w_grant_nxt;
            r_a_ack   <= w_a_ack_nxt;
            r_a_rdata <= w_a_rdata_nxt;
            r_a_err   <= w_a_err_nxt;
            r_d_ack   <= w_d_ack_nxt;
            r_d_rdata <= w_d_rdata_nxt;
            r_d_err   <= w_d_err_nxt;
        end
    end

    assign m_o_stb   = r_stb;
    assign m_o_we    = r_we;
    assign m_o_addr  = r_addr;
    assign m_o_wdata = r_wdata;
    assign m_o_sel   = r_sel;
    assign o_grant   = r_grant;
    assign a_o_ack   = r_a_ack;
    assign a_o_rdata = r_a_rdata;
    assign a_o_err   = r_a_err;
    assign d_o_ack   = r_d_ack;
    assign d_o_rdata = r_d_rdata;
    assign d_o_err   = r_d_err;

endmodule
